// File: rtl/tkm_gate_pkg.sv
// tkm_gate_pkg: op codes and FSM states shared by the bit-serial gate sequencer
package tkm_gate_pkg;
  localparam logic [1:0] OP_XOR  = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/tkm_gate_bit.sv
// tkm_gate_bit: 1-bit gate (a_bit, b_bit, op -> y) applying XOR/AND/OR/NAND
module tkm_gate_bit
  import tkm_gate_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic [1:0] op,
  output logic       y
);
  always_comb
    y = op == OP_XOR ? a_bit ^ b_bit :
        op == OP_AND ? a_bit & b_bit :
        op == OP_OR  ? a_bit | b_bit : ~(a_bit & b_bit);
endmodule

// File: rtl/tkm_gate_sequencer.sv
// tkm_gate_sequencer: two-requester round-robin front end sequencing one gate bit LSB-first into a valid/ready result port
module tkm_gate_sequencer
  import tkm_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state_q, state_d;
  logic rr_q, rr_d, id_q, id_d, gnt1, last, y;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, data_q, data_d;
  logic [1:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  tkm_gate_bit u_bit (
    .a_bit (a_q[cnt_q]),
    .b_bit (b_q[cnt_q]),
    .op    (op_q),
    .y     (y)
  );
  always_comb begin
    gnt1       = req1_valid && (!req0_valid || rr_q);
    req0_ready = state_q == IDLE && req0_valid && !gnt1;
    req1_ready = state_q == IDLE && gnt1;
    last       = cnt_q == CW'(WIDTH - 1);
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    ops_d      = ops_q;
    case (state_q)
      IDLE: if (req0_ready || req1_ready) begin
        a_d     = gnt1 ? req1_a : req0_a;
        b_d     = gnt1 ? req1_b : req0_b;
        op_d    = gnt1 ? req1_op : req0_op;
        id_d    = gnt1;
        rr_d    = !gnt1;
        sr_d    = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sr_d[cnt_q] = y;
        cnt_d       = last ? '0 : cnt_q + CW'(1);
        data_d      = last ? sr_d : data_q;
        state_d     = last ? DONE : RUN;
      end
      DONE: if (rsp_ready) begin
        ops_d   = ops_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ops_q   <= ops_d;
    end
  assign rsp_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign op_count  = ops_q;
endmodule

// File: tb/tb_tkm_gate_sequencer.sv
// tb_tkm_gate_sequencer: randomized and directed bench against a transaction-level model of the gate sequencer
module tb_tkm_gate_sequencer;
  localparam int W = 8;
  localparam int CW = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [1:0] req0_op = 0, req1_op = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [W-1:0] rsp_data;
  logic [CW-1:0] op_count;
  int checks = 0, errors = 0;
  tkm_gate_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .op_count(op_count)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    case (op)
      2'd0: return a ^ b;
      2'd1: return a & b;
      2'd2: return a | b;
      default: return ~(a & b);
    endcase
  endfunction
  int m_st = 0, m_timer = 0;
  logic m_prio = 0, m_id = 0, acc0 = 0, acc1 = 0, m_w;
  logic [W-1:0] m_res = 0, m_data = 0;
  logic [CW-1:0] m_cnt = 0;
  assign m_w = (req0_valid && req1_valid) ? m_prio : req1_valid;
  always @(posedge clk) begin
    acc0 <= 1'b0;
    acc1 <= 1'b0;
    if (rst) begin
      m_st <= 0; m_prio <= 0; m_cnt <= 0; m_data <= 0; m_id <= 0; m_timer <= 0;
    end else if (m_st == 0) begin
      if (req0_valid || req1_valid) begin
        m_id    <= m_w;
        m_res   <= m_w ? calc(req1_a, req1_b, req1_op) : calc(req0_a, req0_b, req0_op);
        m_timer <= W;
        m_st    <= 1;
        m_prio  <= !m_w;
        acc0    <= !m_w;
        acc1    <= m_w;
      end
    end else if (m_st == 1) begin
      if (m_timer == 1) begin
        m_st   <= 2;
        m_data <= m_res;
      end
      m_timer <= m_timer - 1;
    end else if (rsp_ready) begin
      m_st  <= 0;
      m_cnt <= m_cnt + 1'b1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    check("busy", 32'(busy), 32'(m_st != 0));
    check("rsp_valid", 32'(rsp_valid), 32'(m_st == 2));
    check("req0_ready", 32'(req0_ready), 32'(m_st == 0 && req0_valid && !m_w));
    check("req1_ready", 32'(req1_ready), 32'(m_st == 0 && req1_valid && m_w));
    check("rsp_data", 32'(rsp_data), 32'(m_data));
    check("op_count", 32'(op_count), 32'(m_cnt));
    if (m_st == 2) check("rsp_id", 32'(rsp_id), 32'(m_id));
  endtask
  task automatic issue(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    int n = 0;
    if (r == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    else begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    do begin tick(); n++; end while (!(r == 0 ? acc0 : acc1) && n < 50);
    if (n >= 50) check("accept_timeout", 0, 1);
    if (r == 0) req0_valid = 0; else req1_valid = 0;
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin tick(); lat++; end
    if (lat >= 100) check("rsp_timeout", 0, 1);
  endtask
  logic [W-1:0] ta[4] = '{8'hA5, 8'hF0, 8'hF0, 8'hFF};
  logic [W-1:0] tb[4] = '{8'h0F, 8'h3C, 8'h0C, 8'hFF};
  logic [W-1:0] te[4] = '{8'hAA, 8'h30, 8'hFC, 8'h00};
  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int lat, hs, n;
    logic [CW-1:0] c0;
    repeat (2) tick();
    check("reset_busy", 32'(busy), 0);
    check("reset_count", 32'(op_count), 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      issue(0, ta[i], tb[i], 2'(i));
      wait_rsp(lat);
      check("latency", lat, W);
      check("op_data", 32'(rsp_data), 32'(te[i]));
      check("op_id", 32'(rsp_id), 0);
      tick();
    end
    check("op_count4", 32'(op_count), 4);
    rst = 1;
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h03; req0_op = 2'd0;
    req1_valid = 1; req1_a = 8'hFF; req1_b = 8'h81; req1_op = 2'd1;
    tick();
    rst = 0;
    tick();
    req0_valid = 0;
    wait_rsp(lat);
    check("cont_data0", 32'(rsp_data), 8'h02);
    check("cont_id0", 32'(rsp_id), 0);
    tick();
    check("cont_rdy1", 32'(req1_ready), 1);
    tick();
    req1_valid = 0;
    wait_rsp(lat);
    check("cont_data1", 32'(rsp_data), 8'h81);
    check("cont_id1", 32'(rsp_id), 1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    req0_valid = 1; req1_valid = 1;
    req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
    req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom);
    for (int i = 0; i < 6; i++) begin
      wait_rsp(lat);
      check("rr_id", 32'(rsp_id), i % 2);
      if (i == 5) begin req0_valid = 0; req1_valid = 0; end
      tick();
    end
    rsp_ready = 0;
    req1_a = 8'h11; req1_b = 8'h22; req1_op = 2'd3;
    issue(0, 8'h3C, 8'h5A, 2'd2);
    req1_valid = 1;
    wait_rsp(lat);
    c0 = op_count;
    check("bp_first", 32'(rsp_data), 8'h7E);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data", 32'(rsp_data), 8'h7E);
      check("bp_id", 32'(rsp_id), 0);
      check("bp_busy", 32'(busy), 1);
      check("bp_rdy1", 32'(req1_ready), 0);
      check("bp_count", 32'(op_count), 32'(m_cnt));
    end
    rsp_ready = 1;
    req1_valid = 0;
    tick();
    check("bp_count_inc", 32'(op_count), 32'(CW'(c0 + 1'b1)));
    check("bp_idle", 32'(busy), 0);
    issue(0, 8'h55, 8'hFF, 2'd0);
    req0_a = 8'h00;
    wait_rsp(lat);
    check("opchg_data", 32'(rsp_data), 8'hAA);
    tick();
    issue(0, 8'($urandom), 8'($urandom), 2'($urandom));
    tick();
    tick();
    rst = 1;
    tick();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(rsp_valid), 0);
    check("midrst_count", 32'(op_count), 0);
    rst = 0;
    issue(1, 8'hC3, 8'h0F, 2'd1);
    wait_rsp(lat);
    check("postrst_lat", lat, W);
    check("postrst_data", 32'(rsp_data), 8'h03);
    check("postrst_id", 32'(rsp_id), 1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    req0_valid = 1;
    hs = 0;
    n = 0;
    while (hs < 256 && n < 4000) begin
      req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
      tick();
      n++;
      if (rsp_valid) hs++;
    end
    req0_valid = 0;
    tick();
    check("wrap_hs", hs, 256);
    check("wrap_count", 32'(op_count), 0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    rst = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (W + 4) tick();
    check("final_idle", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
